// File: rtl/system_keys_in.sv
// Avalon-MM input PIO: synchronizes and debounces external keys, exposes their level,
// latches selected edges in a sticky register and drives a maskable level interrupt.
module system_keys_in #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam bit                BYPASS  = (DEBOUNCE_CYCLES <= 1);
  localparam int                CNT_W   = BYPASS ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BYPASS ? 0 : DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_unused_wdata;

  assign w_sync         = r_sync[SYNC_STAGES-1];
  assign w_wr           = chipselect && !write_n;
  assign w_unused_wdata = |writedata;

  // --- synchronizer chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // --- debounce: a new level must persist for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else if (BYPASS) begin
      r_stable <= w_sync;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= w_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // --- edge detect and event selection
  assign w_rise = r_stable & ~r_prev;
  assign w_fall = ~r_stable & r_prev;

  always_comb begin
    w_event = w_rise | w_fall;
    if (EDGE_TYPE == 0)      w_event = w_rise;
    else if (EDGE_TYPE == 1) w_event = w_fall;
  end

  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // --- registers: new events win over a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      r_prev <= r_stable;
      r_cap  <= (r_cap & ~w_clr) | w_event;
      if (w_wr && address == 2'd2) r_mask <= writedata[WIDTH-1:0];
    end
  end

  // --- bus read mux and interrupt
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = r_stable;
      2'd2:    readdata[WIDTH-1:0] = r_mask;
      2'd3:    readdata[WIDTH-1:0] = r_cap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_system_keys_in.sv
// Bench for system_keys_in: a rising-edge instance and an any-edge instance share one bus
// and one input port; reads and irq levels are checked against a scoreboard of expectations.
module tb_system_keys_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;

  int n_total = 0;
  int n_pass  = 0;

  system_keys_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  system_keys_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2)
  );

  always #50 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          is_irq;
    bit          d2;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string       name;
    bit          wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    logic        irq_e;
  } vec_t;

  vec_t tbl[$];

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out();
    exp_t        e;
    logic [31:0] act;
    #1;
    e = sb.pop_front();
    if (e.is_irq) act = {31'd0, (e.d2 ? irq2 : irq0)};
    else          act = e.d2 ? rd2 : rd0;
    n_total++;
    if (act === e.exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
  endtask

  task automatic expect_rd(input string nm, input logic [1:0] a, input logic [31:0] e,
                           input bit d2 = 1'b0);
    address = a;
    sb.push_back('{nm, e, 1'b0, d2});
    check_out();
  endtask

  task automatic expect_irq(input string nm, input logic e, input bit d2 = 1'b0);
    sb.push_back('{nm, {31'd0, e}, 1'b1, d2});
    check_out();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input bit cs = 1'b1);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    tbl.push_back('{"cap_after_rise",  1'b0, 2'd3, 32'h00, 32'h05, 1'b0});
    tbl.push_back('{"wr_mask4",        1'b1, 2'd2, 32'h04, 32'h00, 1'b1});
    tbl.push_back('{"rd_mask4",        1'b0, 2'd2, 32'h00, 32'h04, 1'b1});
    tbl.push_back('{"clr_bit2",        1'b1, 2'd3, 32'h04, 32'h00, 1'b0});
    tbl.push_back('{"cap_after_clr",   1'b0, 2'd3, 32'h00, 32'h01, 1'b0});
    tbl.push_back('{"clr_zero",        1'b1, 2'd3, 32'h00, 32'h00, 1'b0});
    tbl.push_back('{"cap_unchanged",   1'b0, 2'd3, 32'h00, 32'h01, 1'b0});
    tbl.push_back('{"wr_mask1",        1'b1, 2'd2, 32'h01, 32'h00, 1'b1});
    tbl.push_back('{"wr_mask0",        1'b1, 2'd2, 32'h00, 32'h00, 1'b0});
    tbl.push_back('{"cap_kept_masked", 1'b0, 2'd3, 32'h00, 32'h01, 1'b0});
    tbl.push_back('{"wr_data_ro",      1'b1, 2'd0, 32'hFF, 32'h00, 1'b0});
    tbl.push_back('{"wr_addr1",        1'b1, 2'd1, 32'hFF, 32'h00, 1'b0});
    tbl.push_back('{"data_kept",       1'b0, 2'd0, 32'h00, 32'h05, 1'b0});
    tbl.push_back('{"addr1_zero",      1'b0, 2'd1, 32'h00, 32'h00, 1'b0});
    tbl.push_back('{"mask_kept",       1'b0, 2'd2, 32'h00, 32'h00, 1'b0});
    tbl.push_back('{"cap_kept",        1'b0, 2'd3, 32'h00, 32'h01, 1'b0});

    // Reset state
    tick(2);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) expect_rd($sformatf("reset_rd%0d", a), 2'(a), 32'h0);
    expect_irq("reset_irq", 1'b0);

    // Step to 0x05: visible on the 6th edge, not the 5th
    in_port = 8'h05;
    tick(5);
    expect_rd("data_lat5", 2'd0, 32'h00);
    tick();
    expect_rd("data_lat6", 2'd0, 32'h05);
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].d);
      else expect_rd(tbl[i].name, tbl[i].a, tbl[i].exp);
      expect_irq({tbl[i].name, "_irq"}, tbl[i].irq_e);
    end

    bus_write(2'd2, 32'hFF, 1'b0);
    expect_rd("no_cs_write", 2'd2, 32'h00);

    // Falling edges are not captured by the rising-edge instance
    bus_write(2'd3, 32'hFF);
    in_port = 8'h00;
    tick(8);
    expect_rd("fall_data", 2'd0, 32'h00);
    expect_rd("fall_no_cap", 2'd3, 32'h00);
    bus_write(2'd3, 32'hFF);

    // Short glitch rejected
    in_port = 8'h01;
    tick(3);
    in_port = 8'h00;
    tick(10);
    expect_rd("glitch_data", 2'd0, 32'h00);
    expect_rd("glitch_cap", 2'd3, 32'h00);

    // Pulse of exactly DEBOUNCE_CYCLES accepted
    in_port = 8'h01;
    tick(4);
    in_port = 8'h00;
    tick(2);
    expect_rd("pulse_data", 2'd0, 32'h01);
    tick(10);
    expect_rd("pulse_cap", 2'd3, 32'h01);
    expect_rd("pulse_data_back", 2'd0, 32'h00);
    bus_write(2'd3, 32'hFF);

    // Clear in the same cycle the event fires: set wins
    in_port = 8'h02;
    tick(6);
    bus_write(2'd3, 32'h02);
    expect_rd("set_wins", 2'd3, 32'h02);
    bus_write(2'd3, 32'h02);
    expect_rd("clr_after", 2'd3, 32'h00);

    // Any-edge instance
    bus_write(2'd3, 32'hFF);
    in_port = 8'h82;
    tick(7);
    expect_rd("any_rise", 2'd3, 32'h80, 1'b1);
    bus_write(2'd3, 32'h80);
    expect_rd("any_cleared", 2'd3, 32'h00, 1'b1);
    in_port = 8'h02;
    tick(7);
    expect_rd("any_fall", 2'd3, 32'h80, 1'b1);
    expect_rd("rise_only_fall", 2'd3, 32'h00);
    bus_write(2'd2, 32'h80);
    expect_irq("any_irq", 1'b1, 1'b1);
    expect_irq("rise_irq", 1'b0);

    // Reset mid-debounce
    in_port = 8'h12;
    tick(3);
    reset_n = 1'b0;
    for (int a = 0; a < 4; a++) expect_rd($sformatf("midrst_rd%0d", a), 2'(a), 32'h0);
    expect_irq("midrst_irq", 1'b0);
    expect_rd("midrst_any_mask", 2'd2, 32'h0, 1'b1);
    expect_irq("midrst_any_irq", 1'b0, 1'b1);
    tick();
    reset_n = 1'b1;
    tick(5);
    expect_rd("post_rst_data5", 2'd0, 32'h00);
    expect_rd("post_rst_cap5", 2'd3, 32'h00);
    tick();
    expect_rd("post_rst_data6", 2'd0, 32'h12);
    tick();
    expect_rd("post_rst_cap7", 2'd3, 32'h12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/system_keys_in.md
Name: system_keys_in

Overview:
- Avalon-MM slave input PIO. Samples external push-buttons/switches, debounces them and exposes their level on the system bus.
- Captures selected edges per bit in a sticky register and raises a maskable level interrupt to the CPU.
- Input-side counterpart of the LED output port. Same bus slave interface, read mux style and register map base.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, synchronizer flops per bit (>=2).
- DEBOUNCE_CYCLES, 50000, cycles a synchronized level must hold before it is accepted; values 0 or 1 bypass debounce.
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  external asynchronous inputs.
- readdata  out  32  read data, zero-extended.
- irq  out  1  level interrupt, active high.

Behaviour:
- One clock domain, clk. Reset is asynchronous, active-low (reset_n); all state clears while reset_n=0.
- Register map:
  - addr 0 DATA: RO, debounced level; writes ignored.
  - addr 1: reads 0, writes ignored.
  - addr 2 IRQ_MASK: RW, WIDTH bits.
  - addr 3 EDGE_CAPTURE: read sticky bits; write-1-to-clear per bit.
- readdata is combinational from address and registers (read latency 0). Bits [31:WIDTH] always read 0.
- Write qualifier: chipselect && !write_n. A write with chipselect=0 has no effect.
- Synchronizer: SYNC_STAGES flops per bit, reset to 0. Output is sync.
- Debounce, per bit:
  - Holds stable and counter cnt, width clog2(DEBOUNCE_CYCLES).
  - If sync==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=sync, cnt<=0.
  - Else cnt<=cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count; no change is accepted.
  - Bypass mode: stable<=sync each cycle.
- Latency, in_port step to DATA: SYNC_STAGES+DEBOUNCE_CYCLES cycles (bypass: SYNC_STAGES+1).
- Edge detect: prev<=stable each cycle.
  - rise = stable & ~prev; fall = ~stable & prev.
  - event selected per EDGE_TYPE; lasts exactly 1 cycle.
- EDGE_CAPTURE bit: set on event; cleared by a write to addr 3 with writedata[i]=1. If set and clear occur in the same cycle, set wins. Writing 0 bits leaves the capture unchanged.
- irq = |(EDGE_CAPTURE & IRQ_MASK), from registered state, so no combinational path from in_port. Masking an already-captured bit drops irq next cycle without clearing the capture.
- Reset values: stable, prev, sync, cnt, IRQ_MASK and EDGE_CAPTURE are all 0; irq=0; readdata reflects registers (0).
- Input held high through reset produces a rising event once debounced after reset release. This is intended, and software clears it at init.
- Reset asserted mid-debounce: count is lost, stable returns to 0, no event is generated.

Test Plan:
- Bench params WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0.
- Reset, then read all addresses -> readdata 0x0 everywhere, irq=0.
- in_port 0x00->0x05, held -> DATA reads 0x05 exactly 6 cycles after the change; EDGE_CAPTURE=0x05; irq=0 (mask 0).
- Write IRQ_MASK=0x04 -> irq=1 next cycle. Write 0x04 to addr 3 -> EDGE_CAPTURE=0x01, irq=0. Write 0x00 to addr 3 -> EDGE_CAPTURE unchanged.
- Bit0 glitch high for 3 cycles, then low -> DATA bit0 stays 0, no capture. Repeat with a 4-cycle-stable pulse -> bit0 accepted and captured.
- Clear bit1 on the same cycle its rising event fires -> EDGE_CAPTURE bit1 remains 1.
- EDGE_TYPE=2 run: 0x80 rises then falls -> capture set on both edges; clear between edges and confirm a re-set.
- Write addr 0 with 0xFF and addr 1 with 0xFF -> no state change; addr 1 reads 0.
- Assert reset_n low mid-debounce -> all registers 0 immediately, irq=0.
